aes_multiblock_fsm: RTL and testbench

Parametrised control FSM for the AES HWPE. It sequences a job of N 128-bit blocks and selectable key length (128/192/256) between the HWPE slave, the plaintext source and ciphertext sink streamers, and the AES engine. It adds config checking, per-block engine handshaking, a block counter, drain of the sink and a watchdog with error reporting. It sits between the register file/slave and the streamer/engine, in place of the single-block controller.

---
 rtl/aes_multiblock_fsm_pkg.sv | 29 ++
 rtl/aes_multiblock_fsm_watchdog.sv | 30 +++
 rtl/aes_multiblock_fsm.sv | 186 ++++++++++++++++++
 tb/tb_aes_multiblock_fsm.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_multiblock_fsm_pkg.sv
// rtl/aes_multiblock_fsm_pkg.sv - shared state type, error codes and key helpers for the multi-block AES controller
package aes_package;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STARTING,
        ISSUE,
        WAIT_BLK,
        DRAIN,
        FINISHED
    } aes_mb_state_t;

    localparam logic [1:0] AES_ERR_OK      = 2'd0;
    localparam logic [1:0] AES_ERR_CFG     = 2'd1;
    localparam logic [1:0] AES_ERR_TIMEOUT = 2'd2;

    localparam logic [1:0] AES_KEY_ILLEGAL = 2'd3;

    // The illegal mode maps to 10 so the latched value stays harmless until CHECK rejects it.
    function automatic logic [3:0] aes_key_rounds(input logic [1:0] key_mode);
        case (key_mode)
            2'd1:    return 4'd12;
            2'd2:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_multiblock_fsm_watchdog.sv
// rtl/aes_multiblock_fsm_watchdog.sv - loadable idle counter that saturates at its terminal value
module aes_watchdog #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == '1);

endmodule

// File: rtl/aes_multiblock_fsm.sv
// rtl/aes_multiblock_fsm.sv - sequences an N-block AES job across slave, streamers and engine
module aes_multiblock_fsm
    import aes_package::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BLK_CNT_W = 16,
    parameter int WORD_W    = 32,
    parameter int WDOG_W    = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      cfg_src_addr_i,
    input  logic [ADDR_W-1:0]      cfg_dst_addr_i,
    input  logic [BLK_CNT_W-1:0]   cfg_n_blocks_i,
    input  logic [1:0]             cfg_key_mode_i,
    input  logic                   cfg_decrypt_i,
    output logic                   src_req_start_o,
    output logic                   snk_req_start_o,
    input  logic                   src_ready_start_i,
    input  logic                   snk_ready_start_i,
    input  logic                   src_done_i,
    input  logic                   snk_done_i,
    output logic [ADDR_W-1:0]      src_base_addr_o,
    output logic [ADDR_W-1:0]      snk_base_addr_o,
    output logic [BLK_CNT_W+1:0]   stream_len_o,
    output logic                   eng_clear_o,
    output logic                   eng_enable_o,
    output logic                   eng_start_o,
    output logic [3:0]             eng_rounds_o,
    output logic                   eng_decrypt_o,
    input  logic                   eng_block_done_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [1:0]             err_o,
    output logic [BLK_CNT_W-1:0]   blocks_done_o
);

    localparam int BLK_WORDS = 128 / WORD_W;
    localparam int LEN_SHIFT = $clog2(BLK_WORDS);
    localparam int LEN_W     = BLK_CNT_W + 2;

    aes_mb_state_t        state;
    logic [BLK_CNT_W-1:0] n_blocks;
    logic [1:0]           key_mode;
    logic                 blk_pending;
    logic                 src_done_seen;
    logic                 snk_done_seen;

    logic counting;
    logic blk_event;
    logic wdog_clear;
    logic wdog_expired;

    assign counting  = (state == STARTING) || (state == WAIT_BLK) || (state == DRAIN);
    assign blk_event = (state == WAIT_BLK) && eng_block_done_i && !blk_pending;

    // Non-counting states hold the counter at zero, so every entry into a counting state starts fresh.
    assign wdog_clear = clear || !counting || blk_pending || blk_event;

    aes_watchdog #(
        .W (WDOG_W)
    ) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (wdog_clear),
        .load       (1'b0),
        .load_value ({WDOG_W{1'b0}}),
        .enable     (counting),
        .expired    (wdog_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            n_blocks        <= '0;
            key_mode        <= '0;
            blk_pending     <= 1'b0;
            src_done_seen   <= 1'b0;
            snk_done_seen   <= 1'b0;
            src_base_addr_o <= '0;
            snk_base_addr_o <= '0;
            stream_len_o    <= '0;
            eng_rounds_o    <= 4'd10;
            eng_decrypt_o   <= 1'b0;
            err_o           <= AES_ERR_OK;
            blocks_done_o   <= '0;
        end else if (clear) begin
            state           <= IDLE;
            n_blocks        <= '0;
            key_mode        <= '0;
            blk_pending     <= 1'b0;
            src_done_seen   <= 1'b0;
            snk_done_seen   <= 1'b0;
            src_base_addr_o <= '0;
            snk_base_addr_o <= '0;
            stream_len_o    <= '0;
            eng_rounds_o    <= 4'd10;
            eng_decrypt_o   <= 1'b0;
            err_o           <= AES_ERR_OK;
            blocks_done_o   <= '0;
        end else begin
            // Leaving CHECK is the entry into STARTING: restart the flags but keep a coincident pulse.
            if (state == CHECK) begin
                src_done_seen <= src_done_i;
                snk_done_seen <= snk_done_i;
            end else if (state != IDLE) begin
                src_done_seen <= src_done_seen | src_done_i;
                snk_done_seen <= snk_done_seen | snk_done_i;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_base_addr_o <= cfg_src_addr_i;
                        snk_base_addr_o <= cfg_dst_addr_i;
                        n_blocks        <= cfg_n_blocks_i;
                        key_mode        <= cfg_key_mode_i;
                        stream_len_o    <= LEN_W'(cfg_n_blocks_i) << LEN_SHIFT;
                        eng_rounds_o    <= aes_key_rounds(cfg_key_mode_i);
                        eng_decrypt_o   <= cfg_decrypt_i;
                        err_o           <= AES_ERR_OK;
                        blocks_done_o   <= '0;
                        state           <= CHECK;
                    end
                end
                CHECK: begin
                    if ((n_blocks == '0) || (key_mode == AES_KEY_ILLEGAL)) begin
                        err_o <= AES_ERR_CFG;
                        state <= FINISHED;
                    end else begin
                        state <= STARTING;
                    end
                end
                STARTING: begin
                    if (src_ready_start_i && snk_ready_start_i) begin
                        state <= ISSUE;
                    end else if (wdog_expired) begin
                        err_o <= AES_ERR_TIMEOUT;
                        state <= FINISHED;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BLK;
                end
                WAIT_BLK: begin
                    // The extra pending cycle compares against the already-updated count.
                    if (blk_pending) begin
                        blk_pending <= 1'b0;
                        state       <= (blocks_done_o == n_blocks) ? DRAIN : ISSUE;
                    end else if (eng_block_done_i) begin
                        blocks_done_o <= blocks_done_o + BLK_CNT_W'(1);
                        blk_pending   <= 1'b1;
                    end else if (wdog_expired) begin
                        err_o <= AES_ERR_TIMEOUT;
                        state <= FINISHED;
                    end
                end
                DRAIN: begin
                    if (snk_done_seen || snk_done_i) begin
                        state <= FINISHED;
                    end else if (wdog_expired) begin
                        err_o <= AES_ERR_TIMEOUT;
                        state <= FINISHED;
                    end
                end
                FINISHED: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o          = (state != IDLE);
    assign eng_clear_o     = (state == IDLE);
    assign eng_enable_o    = (state != IDLE) && (state != CHECK);
    assign src_req_start_o = (state == STARTING);
    assign snk_req_start_o = (state == STARTING);
    assign eng_start_o     = (state == ISSUE);
    assign done_o          = (state == FINISHED);

endmodule

// File: tb/tb_aes_multiblock_fsm.sv
// tb/tb_aes_multiblock_fsm.sv - scoreboard bench for the multi-block AES controller
module tb_aes_multiblock_fsm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] cfg_src_addr_i = '0;
    logic [31:0] cfg_dst_addr_i = '0;
    logic [15:0] cfg_n_blocks_i = '0;
    logic [1:0]  cfg_key_mode_i = '0;
    logic        cfg_decrypt_i = 1'b0;
    logic        src_req_start_o, snk_req_start_o;
    logic        src_ready_start_i = 1'b0;
    logic        snk_ready_start_i = 1'b0;
    logic        src_done_i = 1'b0;
    logic        snk_done_i = 1'b0;
    logic [31:0] src_base_addr_o, snk_base_addr_o;
    logic [17:0] stream_len_o;
    logic        eng_clear_o, eng_enable_o, eng_start_o;
    logic [3:0]  eng_rounds_o;
    logic        eng_decrypt_o;
    logic        eng_block_done_i = 1'b0;
    logic        busy_o, done_o;
    logic [1:0]  err_o;
    logic [15:0] blocks_done_o;

    always #5 clk = ~clk;

    aes_multiblock_fsm dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clear             (clear),
        .start_i           (start_i),
        .cfg_src_addr_i    (cfg_src_addr_i),
        .cfg_dst_addr_i    (cfg_dst_addr_i),
        .cfg_n_blocks_i    (cfg_n_blocks_i),
        .cfg_key_mode_i    (cfg_key_mode_i),
        .cfg_decrypt_i     (cfg_decrypt_i),
        .src_req_start_o   (src_req_start_o),
        .snk_req_start_o   (snk_req_start_o),
        .src_ready_start_i (src_ready_start_i),
        .snk_ready_start_i (snk_ready_start_i),
        .src_done_i        (src_done_i),
        .snk_done_i        (snk_done_i),
        .src_base_addr_o   (src_base_addr_o),
        .snk_base_addr_o   (snk_base_addr_o),
        .stream_len_o      (stream_len_o),
        .eng_clear_o       (eng_clear_o),
        .eng_enable_o      (eng_enable_o),
        .eng_start_o       (eng_start_o),
        .eng_rounds_o      (eng_rounds_o),
        .eng_decrypt_o     (eng_decrypt_o),
        .eng_block_done_i  (eng_block_done_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .blocks_done_o     (blocks_done_o)
    );

    typedef struct {
        logic [1:0]  err;
        int          blocks;
        int          rounds;
        bit          dec;
        int          len;
        logic [31:0] src;
        logic [31:0] dst;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   n_starts = 0;
    int   n_req = 0;
    int   n_done = 0;
    int   eng_delay = 5;
    bit   eng_live = 1'b1;
    int   blk_model = 0;
    int   n_cur = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input int n, input logic [1:0] mode, input bit dec,
                             input logic [1:0] xerr, input int xblocks);
        exp_t e;
        e.src    = $urandom;
        e.dst    = $urandom;
        e.err    = xerr;
        e.blocks = xblocks;
        e.rounds = (mode == 2'd1) ? 12 : (mode == 2'd2) ? 14 : 10;
        e.dec    = dec;
        e.len    = n * 4;
        sb.push_back(e);
        cfg_src_addr_i = e.src;
        cfg_dst_addr_i = e.dst;
        cfg_n_blocks_i = 16'(n);
        cfg_key_mode_i = mode;
        cfg_decrypt_i  = dec;
        n_cur     = n;
        blk_model = 0;
        n_starts  = 0;
        n_req     = 0;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic wait_blocks(input int n);
        for (int i = 0; i < 300 && blocks_done_o != 16'(n); i++) tick();
        check("reach_blocks", blocks_done_o, n);
    endtask

    task automatic drain_and_finish();
        snk_done_i = 1'b1;
        check("done_before_snk", done_o, 0);
        tick();
        snk_done_i = 1'b0;
        check("done_after_snk", done_o, 1);
        tick();
    endtask

    // Engine model: block done a fixed delay after each start, then timing checks on the follow-up.
    initial begin
        bit have;
        have = 1'b0;
        forever begin
            if (!have) @(negedge clk);
            have = 1'b0;
            if (eng_start_o && eng_delay > 0 && eng_live) begin
                repeat (eng_delay) @(posedge clk);
                #1;
                if (eng_live) begin
                    eng_block_done_i = 1'b1;
                    blk_model++;
                    @(posedge clk);
                    #1;
                    eng_block_done_i = 1'b0;
                    @(negedge clk);
                    check("blk_step", blocks_done_o, blk_model);
                    check("blk_gap", eng_start_o, 0);
                    @(negedge clk);
                    check("blk_next_start", eng_start_o, blk_model < n_cur);
                    have = eng_start_o;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (eng_start_o) n_starts++;
            if (src_req_start_o) n_req++;
            if (src_req_start_o || snk_req_start_o) check("req_pair", snk_req_start_o, src_req_start_o);
            if (done_o) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_err", err_o, e.err);
                    check("sb_blocks", blocks_done_o, e.blocks);
                    check("sb_rounds", eng_rounds_o, e.rounds);
                    check("sb_decrypt", eng_decrypt_o, e.dec);
                    check("sb_len", stream_len_o, e.len);
                    check("sb_src", src_base_addr_o, e.src);
                    check("sb_dst", snk_base_addr_o, e.dst);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1);
    end

    initial begin
        int k;
        int d0;
        tick(3);
        reset_n = 1'b1;
        tick();
        check("rst_eng_clear", eng_clear_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_enable", eng_enable_o, 0);
        check("rst_req", src_req_start_o, 0);
        check("rst_err", err_o, 0);
        check("rst_blocks", blocks_done_o, 0);
        check("rst_rounds", eng_rounds_o, 10);
        check("rst_len", stream_len_o, 0);
        check("rst_addr", src_base_addr_o, 0);

        // Nominal three-block job.
        src_ready_start_i = 1'b1;
        snk_ready_start_i = 1'b1;
        start_job(3, 2'd0, 1'b0, 2'd0, 3);
        check("t1_busy", busy_o, 1);
        check("t1_no_req_in_check", src_req_start_o, 0);
        tick();
        check("t1_req", src_req_start_o, 1);
        check("t1_enable", eng_enable_o, 1);
        tick();
        check("t1_issue", eng_start_o, 1);
        check("t1_len", stream_len_o, 12);
        wait_blocks(3);
        tick();
        drain_and_finish();
        check("t1_starts", n_starts, 3);
        check("t1_req_cycles", n_req, 1);

        // Config errors: zero blocks, then illegal key mode.
        start_job(0, 2'd0, 1'b0, 2'd1, 0);
        check("t2a_done_early", done_o, 0);
        tick();
        check("t2a_done", done_o, 1);
        tick();
        check("t2a_no_req", n_req, 0);
        start_job(2, 2'd3, 1'b0, 2'd1, 0);
        check("t2b_done_early", done_o, 0);
        tick();
        check("t2b_done", done_o, 1);
        tick();
        check("t2b_no_req", n_req, 0);

        // 256-bit decrypt with a late sink.
        snk_ready_start_i = 1'b0;
        start_job(1, 2'd2, 1'b1, 2'd0, 1);
        tick(20);
        snk_ready_start_i = 1'b1;
        tick();
        check("t3_issue", eng_start_o, 1);
        check("t3_req_cycles", n_req, 20);
        check("t3_rounds", eng_rounds_o, 14);
        check("t3_decrypt", eng_decrypt_o, 1);
        wait_blocks(1);
        tick();
        drain_and_finish();

        // Engine never finishes a block.
        eng_delay = 0;
        start_job(2, 2'd0, 1'b0, 2'd2, 0);
        k = 1;
        while (!done_o && k < 5000) begin
            tick();
            k++;
        end
        check("t4_done", done_o, 1);
        check("t4_window", (k >= 4095 && k <= 4102), 1);
        check("t4_err", err_o, 2);
        tick();
        eng_delay = 5;

        // Clear during the second block, then a fresh job.
        start_job(3, 2'd0, 1'b0, 2'd0, 3);
        wait_blocks(1);
        tick(2);
        eng_live = 1'b0;
        check("t5_busy_pre", busy_o, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_busy", busy_o, 0);
        check("t5_blocks", blocks_done_o, 0);
        check("t5_eng_clear", eng_clear_o, 1);
        check("t5_no_done", done_o, 0);
        sb.delete();
        d0 = n_done;
        tick(10);
        check("t5_quiet", n_done, d0);
        eng_live = 1'b1;
        start_job(2, 2'd1, 1'b0, 2'd0, 2);
        wait_blocks(2);
        tick();
        drain_and_finish();

        // Early sink done in the last block, and a start while busy.
        d0 = n_done;
        start_job(2, 2'd0, 1'b0, 2'd0, 2);
        wait_blocks(1);
        tick(2);
        start_i        = 1'b1;
        cfg_n_blocks_i = 16'd5;
        cfg_key_mode_i = 2'd3;
        cfg_src_addr_i = ~cfg_src_addr_i;
        snk_done_i     = 1'b1;
        tick();
        start_i    = 1'b0;
        snk_done_i = 1'b0;
        check("t6_busy", busy_o, 1);
        wait_blocks(2);
        tick();
        check("t6_drain", done_o, 0);
        tick();
        check("t6_done", done_o, 1);
        tick(3);
        check("t6_one_done", n_done, d0 + 1);
        check("t6_len", stream_len_o, 8);
        check("t6_idle", busy_o, 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
